// File: rtl/rr_mux_81.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mux_81
//  Brief    : 8:1 round-robin collecting multiplexer. Gathers words from eight
//             request/ack sources into one registered valid/ready output.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_mux_81 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           req,
    input  logic [8*WIDTH-1:0]   din,
    output logic [7:0]           ack,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [2:0]           out_sel,
    input  logic                 out_ready
);

    localparam int c_NSRC = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_ptr;
    logic [7:0]       r_ack;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_sel;

    logic [7:0]       w_elig;
    logic             w_any;
    logic [14:0]      w_dbl;
    logic [7:0]       w_rot;
    logic [2:0]       w_off;
    logic [2:0]       w_g;
    logic             w_grant;
    logic [WIDTH-1:0] w_ch [c_NSRC];

    // Unpack the flattened source bus into one word per channel.
    generate
        for (genvar gi = 0; gi < c_NSRC; gi++) begin : g_unpack
            assign w_ch[gi] = din[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // A source acked this cycle is still presenting the word it just handed
    // over, so it is masked out until it has seen the ack.
    assign w_elig = req & ~r_ack;
    assign w_any  = |w_elig;

    // Rotate the eligible set so that bit 0 corresponds to the pointer; the
    // lowest set bit of the rotated vector is then the offset of the winner.
    assign w_dbl = {w_elig[6:0], w_elig};
    assign w_rot = w_dbl[r_ptr +: 8];

    // Priority-encode the lowest set bit of the rotated eligible vector.
    always_comb begin
        w_off = '0;
        for (int k = c_NSRC - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = 3'(k);
            end
        end
    end

    assign w_g = r_ptr + w_off;

    // Next-state and grant decision; out_ready only matters while holding.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (w_any) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output word, source index, one-cycle ack pulse and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_ack  <= '0;
            r_data <= '0;
            r_sel  <= '0;
        end else begin
            r_ack <= '0;
            if (w_grant) begin
                r_data <= w_ch[w_g];
                r_sel  <= w_g;
                r_ack  <= 8'b1 << w_g;
                r_ptr  <= w_g + 3'd1;
            end
        end
    end

    assign ack       = r_ack;
    assign out_valid = (r_state == HOLD);
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_81.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_mux_81
//  Brief    : Self-checking bench for rr_mux_81: directed scenarios plus
//             randomized sources checked against a cycle reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_81;

    localparam int c_W = 8;

    logic               clk;
    logic               rst;
    logic [7:0]         req;
    logic [8*c_W-1:0]   din;
    logic [7:0]         ack;
    logic               out_valid;
    logic [c_W-1:0]     out_data;
    logic [2:0]         out_sel;
    logic               out_ready;

    int n_cmp;
    int n_err;

    // Reference model state
    bit         m_valid;
    logic [7:0] m_data;
    int         m_sel;
    logic [7:0] m_ack;
    int         m_ptr;
    logic [7:0] prev_ack;

    rr_mux_81 #(.WIDTH(c_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .ack       (ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = '0;
        m_sel    = 0;
        m_ack    = '0;
        m_ptr    = 0;
        prev_ack = '0;
    endtask

    // One clock edge of the behaviour: first eligible source scanning
    // upward from the pointer, modulo 8.
    task automatic model_step();
        logic [7:0] elig;
        bit         do_grant;
        logic [7:0] new_ack;
        elig     = req & ~m_ack;
        do_grant = 1'b0;
        new_ack  = '0;
        if (!m_valid) begin
            do_grant = (elig != 0);
        end else if (out_ready) begin
            if (elig != 0) do_grant = 1'b1;
            else           m_valid = 1'b0;
        end
        if (do_grant) begin
            for (int k = 0; k < 8; k++) begin
                int idx;
                idx = (m_ptr + k) % 8;
                if (elig[idx]) begin
                    m_data       = din[idx*8 +: 8];
                    m_sel        = idx;
                    new_ack[idx] = 1'b1;
                    m_ptr        = (idx + 1) % 8;
                    m_valid      = 1'b1;
                    break;
                end
            end
        end
        m_ack = new_ack;
    endtask

    task automatic tick();
        prev_ack = m_ack;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; din = '0; out_ready = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_cmp++; if (ack !== 8'h00) begin n_err++; $display("FAIL reset_ack: got %h expected 00", ack); end
        n_cmp++; if (out_sel !== 3'd0) begin n_err++; $display("FAIL reset_sel: got %0d expected 0", out_sel); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", out_data); end
        apply_reset();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_noreq_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_single();
        apply_reset();
        req = 8'h04; din[2*8 +: 8] = 8'hA5; out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h expected a5", out_data); end
        n_cmp++; if (out_sel !== 3'd2) begin n_err++; $display("FAIL single_sel: got %0d expected 2", out_sel); end
        n_cmp++; if (ack !== 8'h04) begin n_err++; $display("FAIL single_ack: got %h expected 04", ack); end
        tick();
        n_cmp++; if (ack !== 8'h00) begin n_err++; $display("FAIL single_ack_drop: got %h expected 00", ack); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_to_idle: got %b expected 0", out_valid); end
        req = 8'h00;
        tick();
        n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL idle_hold_data: got %h expected a5", out_data); end
        n_cmp++; if (out_sel !== 3'd2) begin n_err++; $display("FAIL idle_hold_sel: got %0d expected 2", out_sel); end
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int i = 0; i < 8; i++) din[i*8 +: 8] = 8'(8'h10 + i);
        req = 8'hFF; out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            n_cmp++; if (out_sel !== 3'(k % 8)) begin n_err++; $display("FAIL fair_sel[%0d]: got %0d expected %0d", k, out_sel, k % 8); end
            n_cmp++; if (out_data !== 8'(8'h10 + k % 8)) begin n_err++; $display("FAIL fair_data[%0d]: got %h expected %h", k, out_data, 8'(8'h10 + k % 8)); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fair_valid[%0d]: got %b expected 1", k, out_valid); end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        req = '0; din = '0;
        din[0*8 +: 8] = 8'h3C; din[5*8 +: 8] = 8'h5A;
        req = 8'h01; out_ready = 1'b1;
        tick();
        req = 8'h21;
        tick();
        n_cmp++; if (out_sel !== 3'd5) begin n_err++; $display("FAIL stall_grant5_sel: got %0d expected 5", out_sel); end
        n_cmp++; if (ack !== 8'h20) begin n_err++; $display("FAIL stall_grant5_ack: got %h expected 20", ack); end
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (out_sel !== 3'd5) begin n_err++; $display("FAIL stall_sel[%0d]: got %0d expected 5", k, out_sel); end
            n_cmp++; if (out_data !== 8'h5A) begin n_err++; $display("FAIL stall_data[%0d]: got %h expected 5a", k, out_data); end
            n_cmp++; if (ack !== 8'h00) begin n_err++; $display("FAIL stall_ack[%0d]: got %h expected 00", k, ack); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b expected 1", k, out_valid); end
        end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_sel !== 3'd0) begin n_err++; $display("FAIL stall_release_sel: got %0d expected 0", out_sel); end
        n_cmp++; if (out_data !== 8'h3C) begin n_err++; $display("FAIL stall_release_data: got %h expected 3c", out_data); end
        n_cmp++; if (ack !== 8'h01) begin n_err++; $display("FAIL stall_release_ack: got %h expected 01", ack); end
    endtask

    task automatic test_wrap();
        apply_reset();
        din = '0; din[7*8 +: 8] = 8'hE7; din[0*8 +: 8] = 8'h0F;
        req = 8'h80; out_ready = 1'b1;
        tick();
        n_cmp++; if (out_sel !== 3'd7) begin n_err++; $display("FAIL wrap_sel7: got %0d expected 7", out_sel); end
        tick();
        req = 8'h81;
        tick();
        n_cmp++; if (out_sel !== 3'd0) begin n_err++; $display("FAIL wrap_ch0_first: got %0d expected 0", out_sel); end
        tick();
        n_cmp++; if (out_sel !== 3'd7) begin n_err++; $display("FAIL wrap_ch7_second: got %0d expected 7", out_sel); end
        n_cmp++; if (out_data !== 8'hE7) begin n_err++; $display("FAIL wrap_ch7_data: got %h expected e7", out_data); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        din = '0; din[4*8 +: 8] = 8'h44; din[3*8 +: 8] = 8'h33;
        req = 8'h10; out_ready = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre_valid: got %b expected 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
        n_cmp++; if (ack !== 8'h00) begin n_err++; $display("FAIL areset_ack: got %h expected 00", ack); end
        n_cmp++; if (out_sel !== 3'd0) begin n_err++; $display("FAIL areset_sel: got %0d expected 0", out_sel); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL areset_data: got %h expected 00", out_data); end
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        req = 8'h08; out_ready = 1'b1;
        tick();
        n_cmp++; if (out_sel !== 3'd3) begin n_err++; $display("FAIL areset_first_sel: got %0d expected 3", out_sel); end
        n_cmp++; if (out_data !== 8'h33) begin n_err++; $display("FAIL areset_first_data: got %h expected 33", out_data); end
        n_cmp++; if (ack !== 8'h08) begin n_err++; $display("FAIL areset_first_ack: got %h expected 08", ack); end
    endtask

    task automatic test_single_hold();
        apply_reset();
        din = '0; din[1*8 +: 8] = 8'h11;
        req = 8'h02; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [7:0] e_ack;
            e_ack = (k % 2 == 0) ? 8'h02 : 8'h00;
            tick();
            n_cmp++; if (ack !== e_ack) begin n_err++; $display("FAIL hold1_ack[%0d]: got %h expected %h", k, ack, e_ack); end
            n_cmp++; if (out_valid !== (k % 2 == 0)) begin n_err++; $display("FAIL hold1_valid[%0d]: got %b expected %b", k, out_valid, (k % 2 == 0)); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        req = '0; din = '0;
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
            n_cmp++; if (out_valid !== m_valid) begin n_err++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, out_valid, m_valid); end
            n_cmp++; if (ack !== m_ack) begin n_err++; $display("FAIL rand_ack[%0d]: got %h expected %h", c, ack, m_ack); end
            n_cmp++; if (out_sel !== 3'(m_sel)) begin n_err++; $display("FAIL rand_sel[%0d]: got %0d expected %0d", c, out_sel, m_sel); end
            n_cmp++; if (out_data !== m_data) begin n_err++; $display("FAIL rand_data[%0d]: got %h expected %h", c, out_data, m_data); end
            // Sources obey the contract: change only after seeing their ack.
            for (int i = 0; i < 8; i++) begin
                if (req[i] && prev_ack[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else din[i*8 +: 8] = 8'($urandom);
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    din[i*8 +: 8] = 8'($urandom);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        test_reset();
        test_single();
        test_fairness();
        test_stall();
        test_wrap();
        test_async_reset();
        test_single_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
